// File: rtl/owm_slot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : owm_slot_ctrl
// Brief    : 1-wire reset/presence and bit timeslot sequencer. Uses an
//            external counter as a 1 us timebase and drives the pad pull-low.
//            Define OWM_SLOT_OVD_EN to add the ovd input (overdrive timing).
// Revision : 1.0 - initial release
// ============================================================================
module owm_slot_ctrl #(
    parameter int PRD = 50,
    parameter int TW  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_vld,
    output logic          req_rdy,
    input  logic          req_rst,
    input  logic          req_dat,
`ifdef OWM_SLOT_OVD_EN
    input  logic          ovd,
`endif
    output logic          rsp_vld,
    output logic          rsp_dat,
    output logic          busy,
    output logic          tmr_ena,
    output logic          tmr_clr,
    input  logic [TW-1:0] tmr_cnt,
    output logic          owr_e,
    input  logic          owr_i
);

    localparam int c_PSC_W = (PRD > 1) ? $clog2(PRD) : 1;
    localparam logic [c_PSC_W-1:0] c_PSC_MAX = c_PSC_W'(PRD - 1);

    // Standard timing in ticks (1 tick = 1 us)
    localparam logic [TW-1:0] c_STD_R_LOW  = TW'(480);
    localparam logic [TW-1:0] c_STD_R_SMP  = TW'(550);
    localparam logic [TW-1:0] c_STD_R_END  = TW'(960);
    localparam logic [TW-1:0] c_STD_B1_LOW = TW'(6);
    localparam logic [TW-1:0] c_STD_B0_LOW = TW'(60);
    localparam logic [TW-1:0] c_STD_B_SMP  = TW'(15);
    localparam logic [TW-1:0] c_STD_B_END  = TW'(70);
`ifdef OWM_SLOT_OVD_EN
    localparam logic [TW-1:0] c_OVD_R_LOW  = TW'(48);
    localparam logic [TW-1:0] c_OVD_R_SMP  = TW'(56);
    localparam logic [TW-1:0] c_OVD_R_END  = TW'(96);
    localparam logic [TW-1:0] c_OVD_B1_LOW = TW'(1);
    localparam logic [TW-1:0] c_OVD_B0_LOW = TW'(8);
    localparam logic [TW-1:0] c_OVD_B_SMP  = TW'(2);
    localparam logic [TW-1:0] c_OVD_B_END  = TW'(10);
`endif

    // The counter must be able to reach the longest slot end (960 ticks)
    if (TW < 10) begin : g_tw_chk
        $error("owm_slot_ctrl: TW=%0d too narrow, need 2**TW-1 >= 960", TW);
    end
    if (PRD < 1) begin : g_prd_chk
        $error("owm_slot_ctrl: PRD=%0d must be >= 1", PRD);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_rst;
    logic                 r_dat;
`ifdef OWM_SLOT_OVD_EN
    logic                 r_ovd;
`endif
    logic [c_PSC_W-1:0]   r_psc;
    logic                 r_smp;
    logic                 r_smp_done;
    logic                 r_owr_e;
    logic                 r_rsp_vld;
    logic                 r_rsp_dat;

    logic                 w_idle;
    logic                 w_accept;
    logic [TW-1:0]        w_t_low;
    logic [TW-1:0]        w_t_smp;
    logic [TW-1:0]        w_t_end;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = req_vld & w_idle;

    assign req_rdy  = w_idle;
    assign busy     = ~w_idle;
    assign tmr_clr  = w_accept;
    assign tmr_ena  = ~w_idle & (r_psc == c_PSC_MAX);
    assign owr_e    = r_owr_e;
    assign rsp_vld  = r_rsp_vld;
    assign rsp_dat  = r_rsp_dat;

    always_comb begin
        w_t_low = c_STD_B1_LOW;
        w_t_smp = c_STD_B_SMP;
        w_t_end = c_STD_B_END;
        if (r_rst) begin
            w_t_low = c_STD_R_LOW;
            w_t_smp = c_STD_R_SMP;
            w_t_end = c_STD_R_END;
        end else if (!r_dat) begin
            w_t_low = c_STD_B0_LOW;
        end
`ifdef OWM_SLOT_OVD_EN
        if (r_ovd) begin
            if (r_rst) begin
                w_t_low = c_OVD_R_LOW;
                w_t_smp = c_OVD_R_SMP;
                w_t_end = c_OVD_R_END;
            end else begin
                w_t_low = r_dat ? c_OVD_B1_LOW : c_OVD_B0_LOW;
                w_t_smp = c_OVD_B_SMP;
                w_t_end = c_OVD_B_END;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rst      <= 1'b0;
            r_dat      <= 1'b0;
`ifdef OWM_SLOT_OVD_EN
            r_ovd      <= 1'b0;
`endif
            r_psc      <= '0;
            r_smp      <= 1'b0;
            r_smp_done <= 1'b0;
            r_owr_e    <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_rsp_dat  <= 1'b0;
        end else begin
            r_rsp_vld <= 1'b0;

            if (!w_idle) begin
                r_psc <= (r_psc == c_PSC_MAX) ? '0 : r_psc + c_PSC_W'(1);
            end

            // Counter value persists for PRD clocks; only its first cycle samples
            if (!w_idle && !r_smp_done && (tmr_cnt == w_t_smp)) begin
                r_smp      <= r_rst ? ~owr_i : owr_i;
                r_smp_done <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (req_vld) begin
                        r_rst      <= req_rst;
                        r_dat      <= req_dat;
`ifdef OWM_SLOT_OVD_EN
                        r_ovd      <= ovd;
`endif
                        r_psc      <= '0;
                        r_smp_done <= 1'b0;
                        r_owr_e    <= 1'b1;
                        r_state    <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (tmr_cnt == w_t_low) begin
                        r_owr_e <= 1'b0;
                        r_state <= S_REL;
                    end
                end
                S_REL: begin
                    if (tmr_cnt == w_t_end) begin
                        r_rsp_vld <= 1'b1;
                        r_rsp_dat <= r_smp;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_owr_e <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
